// File: rtl/serial_pattern_tx.sv
// Parallel-to-serial transmitter: shifts a WIDTH-bit word out MSB-first with dvalid, then idles for GAP cycles.
// Latency: first bit one cycle after accept; accepts are spaced WIDTH+GAP+1 cycles; load is ignored while ready=0.
module serial_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic             dout,
  output logic             dvalid,
  output logic             done
);

  localparam int BW = $clog2(WIDTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } state_t;

  state_t           state_q, state_nxt;
  logic [WIDTH-1:0] shift_q, shift_nxt;
  logic [BW-1:0]    bit_q, bit_nxt;
  logic [GW-1:0]    gap_q, gap_nxt;
  logic             done_nxt;

  always_comb begin
    state_nxt = state_q;
    shift_nxt = shift_q;
    bit_nxt   = bit_q;
    gap_nxt   = gap_q;
    done_nxt  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          shift_nxt = data;
          bit_nxt   = BIT_LAST;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Shifting in zeros leaves the register clear once the word is out,
        // so dout reads 0 in IDLE/GAP without extra gating.
        shift_nxt = {shift_q[WIDTH-2:0], 1'b0};
        bit_nxt   = bit_q - BW'(1);
        if (bit_q == '0) begin
          bit_nxt  = '0;
          done_nxt = 1'b1;
          if (GAP > 0) begin
            gap_nxt   = GAP_LOAD;
            state_nxt = ST_GAP;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_nxt = ST_IDLE;
        end else begin
          gap_nxt = gap_q - GW'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      done    <= 1'b0;
      dvalid  <= 1'b0;
      ready   <= 1'b1;
    end else begin
      state_q <= state_nxt;
      shift_q <= shift_nxt;
      bit_q   <= bit_nxt;
      gap_q   <= gap_nxt;
      done    <= done_nxt;
      dvalid  <= (state_nxt == ST_SHIFT);
      ready   <= (state_nxt == ST_IDLE);
    end
  end

  assign dout = shift_q[WIDTH-1];

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: three instances (GAP=2, GAP=0, WIDTH=3/GAP=1) checked
// against per-instance bit scoreboards filled when words are loaded.
module tb_serial_pattern_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       load_a, ready_a, dout_a, dvalid_a, done_a;
  logic [7:0] data_a;
  logic       load_b, ready_b, dout_b, dvalid_b, done_b;
  logic [7:0] data_b;
  logic       load_c, ready_c, dout_c, dvalid_c, done_c;
  logic [2:0] data_c;

  serial_pattern_tx #(.WIDTH(8), .GAP(2)) dut_a (
    .clk(clk), .rst(rst), .load(load_a), .data(data_a),
    .ready(ready_a), .dout(dout_a), .dvalid(dvalid_a), .done(done_a));
  serial_pattern_tx #(.WIDTH(8), .GAP(0)) dut_b (
    .clk(clk), .rst(rst), .load(load_b), .data(data_b),
    .ready(ready_b), .dout(dout_b), .dvalid(dvalid_b), .done(done_b));
  serial_pattern_tx #(.WIDTH(3), .GAP(1)) dut_c (
    .clk(clk), .rst(rst), .load(load_c), .data(data_c),
    .ready(ready_c), .dout(dout_c), .dvalid(dvalid_c), .done(done_c));

  bit q_a[$];
  bit q_b[$];
  bit q_c[$];
  int checks = 0;
  int passed = 0;
  int done_cnt_b = 0;
  int done_cnt_c = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_word(input int width, input logic [31:0] w, input int which);
    for (int i = width - 1; i >= 0; i--) begin
      if (which == 0) q_a.push_back(w[i]);
      else if (which == 1) q_b.push_back(w[i]);
      else q_c.push_back(w[i]);
    end
  endtask

  // One clock: outputs are sampled 1 ns after the edge and every valid bit is scoreboarded.
  task automatic tick();
    @(posedge clk);
    #1;
    if (done_b === 1'b1) done_cnt_b++;
    if (done_c === 1'b1) done_cnt_c++;
    if (dvalid_a === 1'b1) begin
      if (q_a.size() == 0) chk("spurious_dvalid_a", 32'(dvalid_a), 32'd0);
      else chk("bit_a", 32'(dout_a), 32'(q_a.pop_front()));
    end
    if (dvalid_b === 1'b1) begin
      if (q_b.size() == 0) chk("spurious_dvalid_b", 32'(dvalid_b), 32'd0);
      else chk("bit_b", 32'(dout_b), 32'(q_b.pop_front()));
    end
    if (dvalid_c === 1'b1) begin
      if (q_c.size() == 0) chk("spurious_dvalid_c", 32'(dvalid_c), 32'd0);
      else chk("bit_c", 32'(dout_c), 32'(q_c.pop_front()));
    end
  endtask

  task automatic wait_ready_a(input int limit);
    int n = 0;
    while (ready_a !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    if (ready_a !== 1'b1) chk("wait_ready_a_timeout", 32'(ready_a), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    load_a = 1'b1; data_a = 8'hA5;
    load_b = 1'b0; data_b = 8'h00;
    load_c = 1'b0; data_c = 3'd0;

    // Reset held with load asserted: nothing may be captured.
    repeat (3) begin
      tick();
      chk("rst_ready", 32'(ready_a), 32'd1);
      chk("rst_dout", 32'(dout_a), 32'd0);
      chk("rst_dvalid", 32'(dvalid_a), 32'd0);
      chk("rst_done", 32'(done_a), 32'd0);
    end
    rst = 1'b0;
    load_a = 1'b0;
    repeat (3) tick();
    chk("post_rst_idle_dvalid", 32'(dvalid_a), 32'd0);
    chk("post_rst_idle_ready", 32'(ready_a), 32'd1);

    // Single word 1011_0010 with GAP=2.
    load_a = 1'b1; data_a = 8'b1011_0010;
    push_word(8, 32'(data_a), 0);
    tick();
    load_a = 1'b0;
    chk("single_ready_drop", 32'(ready_a), 32'd0);
    chk("single_first_dvalid", 32'(dvalid_a), 32'd1);
    tick();
    chk("single_done_low_in_shift", 32'(done_a), 32'd0);
    repeat (6) tick();
    tick();
    chk("single_done_pulse", 32'(done_a), 32'd1);
    chk("single_gap1_dvalid", 32'(dvalid_a), 32'd0);
    chk("single_gap1_ready", 32'(ready_a), 32'd0);
    chk("single_gap1_dout", 32'(dout_a), 32'd0);
    tick();
    chk("single_done_one_cycle", 32'(done_a), 32'd0);
    chk("single_gap2_ready", 32'(ready_a), 32'd0);
    tick();
    chk("single_ready_back", 32'(ready_a), 32'd1);
    chk("single_queue_empty", 32'(q_a.size()), 32'd0);

    // Load of FF while shifting 00 must be ignored, not queued.
    load_a = 1'b1; data_a = 8'h00;
    push_word(8, 32'h00, 0);
    tick();
    data_a = 8'hFF;
    repeat (3) tick();
    load_a = 1'b0;
    wait_ready_a(20);
    repeat (4) tick();
    chk("ignored_queue_empty", 32'(q_a.size()), 32'd0);
    chk("ignored_no_second_word", 32'(dvalid_a), 32'd0);

    // Back-to-back with GAP=0: load held high across the word boundary.
    load_b = 1'b1; data_b = 8'hF0;
    push_word(8, 32'hF0, 1);
    push_word(8, 32'h0F, 1);
    tick();
    data_b = 8'h0F;
    repeat (8) tick();
    chk("b2b_idle_done", 32'(done_b), 32'd1);
    chk("b2b_idle_ready", 32'(ready_b), 32'd1);
    chk("b2b_idle_dvalid", 32'(dvalid_b), 32'd0);
    tick();
    load_b = 1'b0;
    chk("b2b_second_start", 32'(dvalid_b), 32'd1);
    chk("b2b_done_cleared", 32'(done_b), 32'd0);
    repeat (8) tick();
    chk("b2b_final_ready", 32'(ready_b), 32'd1);
    tick();
    chk("b2b_done_count", 32'(done_cnt_b), 32'd2);
    chk("b2b_queue_empty", 32'(q_b.size()), 32'd0);

    // Reset after three bits of FF drops the word with no done.
    load_a = 1'b1; data_a = 8'hFF;
    push_word(8, 32'hFF, 0);
    tick();
    load_a = 1'b0;
    repeat (2) tick();
    chk("midrst_before_dvalid", 32'(dvalid_a), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_dvalid", 32'(dvalid_a), 32'd0);
    chk("midrst_dout", 32'(dout_a), 32'd0);
    chk("midrst_ready", 32'(ready_a), 32'd1);
    chk("midrst_done", 32'(done_a), 32'd0);
    chk("midrst_bits_seen", 32'(q_a.size()), 32'd5);
    q_a.delete();
    repeat (3) begin
      tick();
      chk("midrst_no_done", 32'(done_a), 32'd0);
    end

    // WIDTH=3, GAP=1 loopback of patterns 0..7 at minimum spacing.
    for (int p = 0; p < 8; p++) begin
      chk("loop_ready_before", 32'(ready_c), 32'd1);
      load_c = 1'b1; data_c = 3'(p);
      push_word(3, 32'(p), 2);
      tick();
      load_c = 1'b0;
      chk("loop_ready_drop", 32'(ready_c), 32'd0);
      repeat (3) tick();
      chk("loop_ready_in_gap", 32'(ready_c), 32'd0);
      tick();
    end
    tick();
    chk("loop_queue_empty", 32'(q_c.size()), 32'd0);
    chk("loop_done_count", 32'(done_cnt_c), 32'd8);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
- Parallel-to-serial bit-stream transmitter; the driving end of the single-bit `din` serial interface consumed by the serial sequence detectors.
- Accepts a WIDTH-bit word on a load/ready handshake and shifts it out MSB-first, one bit per clock, on `dout`, qualified by `dvalid`.
- Inserts a configurable idle gap between words so the downstream detector sees defined frame boundaries.
- Used as synthesizable stimulus source and as the serial front end for board-level detector tests.

Parameters:
- WIDTH, 8, bits per word shifted out (legal range 2..32).
- GAP, 2, idle cycles forced between consecutive words (legal range 0..15); `dout` = 0 during the gap.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- load  input  1  request to transmit `data`; accepted only when `ready`=1
- data  input  WIDTH  word to transmit, sampled on the accepted `load` cycle
- ready  output  1  1 = block can accept a new word this cycle
- dout  output  1  serial data bit, MSB first
- dvalid  output  1  1 = `dout` carries a payload bit this cycle
- done  output  1  one-cycle pulse in the cycle after the last bit of a word

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, shift register=0, bit counter=0, gap counter=0.
  - Outputs after reset: ready=1, dout=0, dvalid=0, done=0.
  - Reset wins over everything, including mid-word or mid-gap; a partially sent word is dropped with no `done` pulse.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - ready=1, dvalid=0, dout=0.
  - On load=1: capture `data` into the shift register, set bit counter=WIDTH-1, go to SHIFT. ready drops on the next cycle.
- SHIFT:
  - ready=0, dvalid=1, dout=shift_reg[WIDTH-1].
  - Each cycle: shift left by 1 (LSB filled with 0), decrement bit counter.
  - When bit counter=0 (last bit on the line this cycle):
    - GAP>0: go to GAP and load gap counter=GAP-1.
    - GAP=0: go to IDLE.
- GAP:
  - ready=0, dvalid=0, dout=0.
  - Decrement gap counter each cycle; go to IDLE when it reaches 0.
- Latency:
  - First payload bit appears on `dout` the cycle after load is accepted.
  - A word occupies exactly WIDTH cycles of dvalid=1.
  - Minimum accept-to-accept spacing is WIDTH+GAP+1 cycles.
- done:
  - Registered pulse, high for exactly one cycle, in the first cycle after the last payload bit (i.e. the first GAP cycle, or the first IDLE cycle when GAP=0).
- load handling:
  - load while ready=0 is ignored, not queued.
  - `data` changes while not accepting have no effect.
- Simultaneous events:
  - load=1 with rst=1: reset wins, nothing is captured.
  - With GAP=0, load in the first IDLE cycle after a word is accepted normally. That cycle has done=1 and ready=1 together, so back-to-back words are separated by exactly one idle cycle.
- Counter widths are sized by clog2 of WIDTH and GAP; no wrap-around is reachable in legal ranges.
- `dout` and `dvalid` are registered outputs, with no combinational path from `load` or `data`.

Test Plan:
- Reset: hold rst=1 for 3 cycles with load=1, data=8'hA5 -> ready=1, dout=0, dvalid=0, done=0 throughout; no transmission starts after rst falls until a new load.
- Single word: WIDTH=8, GAP=2, load 8'b1011_0010 -> dout sequence 1,0,1,1,0,0,1,0 with dvalid=1 for 8 cycles starting 1 cycle after accept; done=1 on the 9th cycle; ready returns 1 after 2 gap cycles.
- Ignored load: assert load with 8'hFF during SHIFT of word 8'h00 -> dout stays 0 for all 8 bits; no second word follows.
- Back-to-back: GAP=0, re-assert load immediately when ready rises, data 8'hF0 then 8'h0F -> bits 11110000, one idle cycle with dvalid=0, then 00001111; done pulses twice.
- Mid-word reset: load 8'hFF, assert rst after 3 bits -> next cycle dvalid=0, dout=0, ready=1; no done pulse.
- Loopback: feed `dout` into the serial sequence detector's `din` with patterns 0..7 as 3-bit words (WIDTH=3, GAP=1) -> detector output matches its reference model bit for bit.
